// File: rtl/alu_operand_sequencer.sv
// Serial nibble collector for the 4-bit ALU: gathers opcode, A and B nibbles,
// then presents the assembled operation through a valid/ready handshake.
module alu_operand_sequencer #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ena,
   input  logic [WIDTH-1:0] in_data,
   input  logic             clr_ovr,
   input  logic             issue_ready,
   output logic             issue_valid,
   output logic [WIDTH-1:0] opcode,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             overrun,
   output logic [CNT_W-1:0] issue_cnt
);

   typedef enum logic [1:0] {
      S_OP    = 2'd0,
      S_A     = 2'd1,
      S_B     = 2'd2,
      S_ISSUE = 2'd3
   } state_t;

   state_t             r_state;
   logic               r_valid;
   logic [WIDTH-1:0]   r_opcode;
   logic [WIDTH-1:0]   r_op_a;
   logic [WIDTH-1:0]   r_op_b;
   logic               r_busy;
   logic               r_overrun;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_handshake;
   logic               w_drop;

   assign w_handshake = r_valid && issue_ready;
   // A nibble arriving while the operation is still waiting for the ALU is lost.
   assign w_drop      = (r_state == S_ISSUE) && ena && !issue_ready;

   // Frame collection and issue FSM; busy is registered from the next state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_OP;
         r_valid  <= 1'b0;
         r_opcode <= '0;
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_busy   <= 1'b0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            S_OP: begin
               if (ena) begin
                  r_opcode <= in_data;
                  r_state  <= S_A;
                  r_busy   <= 1'b1;
               end
            end
            S_A: begin
               if (ena) begin
                  r_op_a  <= in_data;
                  r_state <= S_B;
               end
            end
            S_B: begin
               if (ena) begin
                  r_op_b  <= in_data;
                  r_valid <= 1'b1;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (w_handshake) begin
                  r_valid <= 1'b0;
                  r_cnt   <= r_cnt + CNT_W'(1);
                  // Zero-bubble: the nibble in the handshake cycle opens the next frame.
                  if (ena) begin
                     r_opcode <= in_data;
                     r_state  <= S_A;
                     r_busy   <= 1'b1;
                  end else begin
                     r_state  <= S_OP;
                     r_busy   <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= S_OP;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Sticky overrun; a drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_overrun <= 1'b0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
      end else if (clr_ovr) begin
         r_overrun <= 1'b0;
      end
   end

   assign issue_valid = r_valid;
   assign opcode      = r_opcode;
   assign op_a        = r_op_a;
   assign op_b        = r_op_b;
   assign busy        = r_busy;
   assign overrun     = r_overrun;
   assign issue_cnt   = r_cnt;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer: directed vector table,
// hand-written reset/wrap sequences and randomized traffic against a frame model.
module tb_alu_operand_sequencer;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             ena;
   logic [WIDTH-1:0] in_data;
   logic             clr_ovr;
   logic             issue_ready;
   logic             issue_valid;
   logic [WIDTH-1:0] opcode;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             overrun;
   logic [CNT_W-1:0] issue_cnt;

   always #5 clk = ~clk;

   alu_operand_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .ena         (ena),
      .in_data     (in_data),
      .clr_ovr     (clr_ovr),
      .issue_ready (issue_ready),
      .issue_valid (issue_valid),
      .opcode      (opcode),
      .op_a        (op_a),
      .op_b        (op_b),
      .busy        (busy),
      .overrun     (overrun),
      .issue_cnt   (issue_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Frame-level reference: how many nibbles of the current frame are held,
   // whether a complete operation awaits the ALU, and the latest nibble values.
   int         m_fill;
   bit         m_pending;
   logic [3:0] m_op, m_a, m_b;
   bit         m_ovr;
   int         m_cnt;

   typedef struct {
      logic       ena;
      logic [3:0] d;
      logic       clr;
      logic       rdy;
      logic       v;
      logic [3:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic       busy;
      logic       ovr;
      logic [7:0] cnt;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_fill = 0; m_pending = 0; m_op = 0; m_a = 0; m_b = 0; m_ovr = 0; m_cnt = 0;
   endtask

   task automatic model_step(input logic e, input logic [3:0] d, input logic c, input logic r);
      bit drop;
      drop = 0;
      if (m_pending) begin
         if (r) begin
            m_pending = 0;
            m_cnt++;
            if (e) begin m_op = d; m_fill = 1; end
            else m_fill = 0;
         end else if (e) begin
            drop = 1;
         end
      end else if (e) begin
         if (m_fill == 0) m_op = d;
         else if (m_fill == 1) m_a = d;
         else m_b = d;
         m_fill++;
         if (m_fill == 3) begin m_fill = 0; m_pending = 1; end
      end
      if (drop) m_ovr = 1;
      else if (c) m_ovr = 0;
   endtask

   task automatic check_model(input string tag);
      check({tag, "_valid"}, 32'(issue_valid), 32'(m_pending));
      check({tag, "_opcode"}, 32'(opcode), 32'(m_op));
      check({tag, "_op_a"}, 32'(op_a), 32'(m_a));
      check({tag, "_op_b"}, 32'(op_b), 32'(m_b));
      check({tag, "_busy"}, 32'(busy), 32'(m_pending || (m_fill != 0)));
      check({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
      check({tag, "_cnt"}, 32'(issue_cnt), 32'(m_cnt % 256));
   endtask

   task automatic cycle(input logic e, input logic [3:0] d, input logic c, input logic r, input string tag);
      ena = e; in_data = d; clr_ovr = c; issue_ready = r;
      @(posedge clk);
      model_step(e, d, c, r);
      #1;
      check_model(tag);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, 32'(issue_valid), 32'd0);
      check({tag, "_opcode"}, 32'(opcode), 32'd0);
      check({tag, "_op_a"}, 32'(op_a), 32'd0);
      check({tag, "_op_b"}, 32'(op_b), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_overrun"}, 32'(overrun), 32'd0);
      check({tag, "_cnt"}, 32'(issue_cnt), 32'd0);
   endtask

   task automatic do_frame(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b);
      cycle(1'b1, o, 1'b0, 1'b0, "wrap");
      cycle(1'b1, a, 1'b0, 1'b0, "wrap");
      cycle(1'b1, b, 1'b0, 1'b0, "wrap");
      cycle(1'b0, 4'h0, 1'b0, 1'b1, "wrap");
   endtask

   initial begin
      //            ena d     clr rdy  v  op    a     b     bsy ovr cnt
      vecs[0]  = '{1, 4'h2, 0, 0,   0, 4'h2, 4'h0, 4'h0, 1, 0, 8'd0};
      vecs[1]  = '{1, 4'h5, 0, 0,   0, 4'h2, 4'h5, 4'h0, 1, 0, 8'd0};
      vecs[2]  = '{1, 4'h3, 0, 0,   1, 4'h2, 4'h5, 4'h3, 1, 0, 8'd0};
      vecs[3]  = '{0, 4'h0, 0, 0,   1, 4'h2, 4'h5, 4'h3, 1, 0, 8'd0};
      vecs[4]  = '{0, 4'h0, 0, 1,   0, 4'h2, 4'h5, 4'h3, 0, 0, 8'd1};
      vecs[5]  = '{1, 4'h8, 0, 0,   0, 4'h8, 4'h5, 4'h3, 1, 0, 8'd1};
      vecs[6]  = '{1, 4'h1, 0, 0,   0, 4'h8, 4'h1, 4'h3, 1, 0, 8'd1};
      vecs[7]  = '{1, 4'h2, 0, 0,   1, 4'h8, 4'h1, 4'h2, 1, 0, 8'd1};
      vecs[8]  = '{1, 4'hF, 0, 0,   1, 4'h8, 4'h1, 4'h2, 1, 1, 8'd1};
      vecs[9]  = '{0, 4'h0, 1, 0,   1, 4'h8, 4'h1, 4'h2, 1, 0, 8'd1};
      vecs[10] = '{1, 4'hF, 1, 0,   1, 4'h8, 4'h1, 4'h2, 1, 1, 8'd1};
      vecs[11] = '{0, 4'h0, 1, 0,   1, 4'h8, 4'h1, 4'h2, 1, 0, 8'd1};
      vecs[12] = '{0, 4'h0, 0, 1,   0, 4'h8, 4'h1, 4'h2, 0, 0, 8'd2};
      vecs[13] = '{1, 4'h1, 0, 1,   0, 4'h1, 4'h1, 4'h2, 1, 0, 8'd2};
      vecs[14] = '{1, 4'h2, 0, 1,   0, 4'h1, 4'h2, 4'h2, 1, 0, 8'd2};
      vecs[15] = '{1, 4'h3, 0, 1,   1, 4'h1, 4'h2, 4'h3, 1, 0, 8'd2};
      vecs[16] = '{1, 4'h4, 0, 1,   0, 4'h4, 4'h2, 4'h3, 1, 0, 8'd3};
      vecs[17] = '{1, 4'h5, 0, 1,   0, 4'h4, 4'h5, 4'h3, 1, 0, 8'd3};
      vecs[18] = '{1, 4'h6, 0, 1,   1, 4'h4, 4'h5, 4'h6, 1, 0, 8'd3};
      vecs[19] = '{0, 4'h0, 0, 1,   0, 4'h4, 4'h5, 4'h6, 0, 0, 8'd4};

      reset = 1'b0; ena = 1'b0; in_data = '0; clr_ovr = 1'b0; issue_ready = 1'b0;
      model_reset();
      #1;
      check_zero("reset");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Directed table: capture, hold, handshake, overrun/clear, zero-bubble stream.
      for (int i = 0; i < 20; i++) begin
         cycle(vecs[i].ena, vecs[i].d, vecs[i].clr, vecs[i].rdy, $sformatf("vec%0d_model", i));
         check($sformatf("vec%0d_valid", i), 32'(issue_valid), 32'(vecs[i].v));
         check($sformatf("vec%0d_opcode", i), 32'(opcode), 32'(vecs[i].op));
         check($sformatf("vec%0d_op_a", i), 32'(op_a), 32'(vecs[i].a));
         check($sformatf("vec%0d_op_b", i), 32'(op_b), 32'(vecs[i].b));
         check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
         check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vecs[i].ovr));
         check($sformatf("vec%0d_cnt", i), 32'(issue_cnt), 32'(vecs[i].cnt));
         if (i == 3) begin
            // Operation must stay stable while the ALU withholds ready.
            for (int h = 0; h < 10; h++) cycle(1'b0, 4'h0, 1'b0, 1'b0, "hold");
         end
      end

      // Asynchronous reset mid-frame, then a fresh frame.
      cycle(1'b1, 4'h7, 1'b0, 1'b0, "midrst");
      cycle(1'b1, 4'h9, 1'b0, 1'b0, "midrst");
      ena = 1'b0;
      #2 reset = 1'b0;
      #1;
      check_zero("async_rst");
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      cycle(1'b1, 4'h1, 1'b0, 1'b0, "post_rst");
      cycle(1'b1, 4'h1, 1'b0, 1'b0, "post_rst");
      cycle(1'b1, 4'h1, 1'b0, 1'b0, "post_rst");
      check("post_rst_valid", 32'(issue_valid), 32'd1);
      check("post_rst_opcode", 32'(opcode), 32'd1);
      check("post_rst_op_a", 32'(op_a), 32'd1);
      check("post_rst_op_b", 32'(op_b), 32'd1);

      // Counter wrap: fresh reset then 256 handshakes.
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      for (int f = 0; f < 255; f++) do_frame(4'(f), 4'(f + 1), 4'(f + 2));
      check("wrap_cnt_255", 32'(issue_cnt), 32'd255);
      do_frame(4'hA, 4'hB, 4'hC);
      check("wrap_cnt_0", 32'(issue_cnt), 32'd0);

      // Randomized traffic against the frame model.
      for (int k = 0; k < 3000; k++) begin
         cycle(1'($urandom_range(0, 9) < 6), 4'($urandom),
               1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
